// File: rtl/int_sequencer_if.sv
// Pin/control bundle between the interrupt sequencer and its surroundings.
// The slave modport is the sequencer; the master side drives pins and observes controls.
interface int_sequencer_if;
  logic        NMI_L;
  logic        IRQ_L;
  logic        RES_L;
  logic        RDY;
  logic        SYNC;
  logic        I_flag;
  logic        busy;
  logic        forceBRK;
  logic        pcHold;
  logic        pushEn;
  logic [1:0]  pushSel;
  logic        RW;
  logic        stackDec;
  logic [15:0] vecAddr;
  logic        setI;
  logic        intDone;
  logic [1:0]  srcCode;

  modport master (
    output NMI_L, IRQ_L, RES_L, RDY, SYNC, I_flag,
    input  busy, forceBRK, pcHold, pushEn, pushSel, RW, stackDec,
           vecAddr, setI, intDone, srcCode
  );

  modport slave (
    input  NMI_L, IRQ_L, RES_L, RDY, SYNC, I_flag,
    output busy, forceBRK, pcHold, pushEn, pushSel, RW, stackDec,
           vecAddr, setI, intDone, srcCode
  );
endinterface

// File: rtl/int_sequencer.sv
// 6502C interrupt/reset entry sequencer: RES > NMI > IRQ arbitration and 7-cycle BRK entry.
// Optional macro INT_NMI_HIJACK_EN lets an NMI arriving during an IRQ entry take over its vector fetch.
module int_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RES_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input logic            clock,
  input logic            reset,
  int_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RHOLD, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0, SRC_RES = 2'd1, SRC_NMI = 2'd2, SRC_IRQ = 2'd3
  } src_e;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [15:0] base_q, base_d;
  logic        nmi_prev_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_edge, nmi_any, irq_req;

  assign nmi_edge = nmi_prev_q & ~bus.NMI_L;
  assign nmi_any  = nmi_pend_q | nmi_edge;
  assign irq_req  = ~bus.IRQ_L & ~bus.I_flag;

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    base_d     = base_q;
    nmi_pend_d = nmi_pend_q | nmi_edge;
    if (!bus.RES_L) begin
      state_d    = ST_RHOLD;
      src_d      = SRC_NONE;
      nmi_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.RDY && bus.SYNC && (nmi_any || irq_req)) begin
          state_d = ST_S1;
          src_d   = nmi_any ? SRC_NMI : SRC_IRQ;
        end
        ST_RHOLD: begin
          state_d = ST_S1;
          src_d   = SRC_RES;
        end
        ST_S1: if (bus.RDY) state_d = ST_S2;
        ST_S2: if (bus.RDY) state_d = ST_S3;
        ST_S3: state_d = ST_S4;
        ST_S4: state_d = ST_S5;
        ST_S5: begin
          state_d = ST_S6;
`ifdef INT_NMI_HIJACK_EN
          if (src_q == SRC_IRQ && nmi_any) src_d = SRC_NMI;
`endif
          case (src_d)
            SRC_RES: base_d = RES_VEC;
            SRC_NMI: base_d = NMI_VEC;
            default: base_d = IRQ_VEC;
          endcase
          // An edge landing now on an NMI already in service is a fresh NMI and stays pending.
          if (src_d == SRC_NMI) nmi_pend_d = (src_q == SRC_NMI) ? nmi_edge : 1'b0;
        end
        ST_S6: if (bus.RDY) state_d = ST_S7;
        ST_S7: if (bus.RDY) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      base_q     <= 16'h0000;
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      base_q     <= base_d;
      nmi_prev_q <= bus.NMI_L;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  // Moore decode: outputs depend only on registered state, so RDY stalls hold them naturally.
  always_comb begin
    bus.busy     = 1'b1;
    bus.forceBRK = 1'b0;
    bus.pcHold   = 1'b0;
    bus.pushEn   = 1'b0;
    bus.pushSel  = 2'd0;
    bus.RW       = 1'b1;
    bus.stackDec = 1'b0;
    bus.vecAddr  = 16'h0000;
    bus.setI     = 1'b0;
    bus.intDone  = 1'b0;
    bus.srcCode  = src_q;
    case (state_q)
      ST_IDLE: bus.busy = 1'b0;
      ST_S1: begin
        bus.forceBRK = 1'b1;
        bus.pcHold   = 1'b1;
      end
      ST_S2: bus.pcHold = 1'b1;
      ST_S3, ST_S4, ST_S5: begin
        bus.stackDec = 1'b1;
        bus.pushEn   = (src_q != SRC_RES);
        bus.RW       = (src_q == SRC_RES);
        case (state_q)
          ST_S3:   bus.pushSel = 2'd0;
          ST_S4:   bus.pushSel = 2'd1;
          default: bus.pushSel = 2'd2;
        endcase
      end
      ST_S6: begin
        bus.vecAddr = base_q;
        bus.setI    = 1'b1;
      end
      ST_S7: begin
        bus.vecAddr = base_q + 16'd1;
        bus.pcHold  = 1'b1;
        bus.intDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: per-cycle vector tables feed a scoreboard queue
// that a negedge monitor drains and compares against the DUT outputs.
module tb_int_sequencer;

  typedef struct packed {
    logic        busy;
    logic        force_brk;
    logic        pc_hold;
    logic        push_en;
    logic [1:0]  push_sel;
    logic        rw;
    logic        stack_dec;
    logic [15:0] vec_addr;
    logic        set_i;
    logic        int_done;
    logic [1:0]  src_code;
  } exp_t;

  typedef struct {
    logic nmi_l, irq_l, res_l, rdy, sync, i_flag;
    exp_t e;
    int   tag;
    int   idx;
  } vec_t;

  localparam int IDLE  = 0;
  localparam int RHOLD = 8;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur_tag  = 0;
  vec_t tbl[$];
  vec_t sb[$];

  int_sequencer_if bus ();

  int_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs for phase s (0 idle, 1..7 entry cycles, 8 reset hold) and source code.
  function automatic exp_t ph(input int s, input logic [1:0] src);
    exp_t        e;
    logic [15:0] base;
    e    = '0;
    e.rw = 1'b1;
    base = (src == 2'd1) ? 16'hFFFC : (src == 2'd2) ? 16'hFFFA : 16'hFFFE;
    if (s != IDLE && s != RHOLD) e.src_code = src;
    if (s != IDLE) e.busy = 1'b1;
    case (s)
      1: begin e.force_brk = 1'b1; e.pc_hold = 1'b1; end
      2: e.pc_hold = 1'b1;
      3, 4, 5: begin
        e.stack_dec = 1'b1;
        e.push_sel  = 2'(s - 3);
        if (src != 2'd1) begin e.push_en = 1'b1; e.rw = 1'b0; end
      end
      6: begin e.vec_addr = base; e.set_i = 1'b1; end
      7: begin e.vec_addr = base + 16'd1; e.pc_hold = 1'b1; e.int_done = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.busy      = bus.busy;
    a.force_brk = bus.forceBRK;
    a.pc_hold   = bus.pcHold;
    a.push_en   = bus.pushEn;
    a.push_sel  = bus.pushSel;
    a.rw        = bus.RW;
    a.stack_dec = bus.stackDec;
    a.vec_addr  = bus.vecAddr;
    a.set_i     = bus.setI;
    a.int_done  = bus.intDone;
    a.src_code  = bus.srcCode;
    return a;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (busy,brk,pch,pen,psel,rw,sdec,vec,seti,done,src)",
               name, act, exp);
    end
  endtask

  // Append one cycle: pins applied this cycle, outputs expected during this same cycle.
  task automatic add(input logic nmi_l, irq_l, res_l, rdy, sync, i_flag,
                     input int s, input logic [1:0] src);
    vec_t v;
    v.nmi_l = nmi_l; v.irq_l = irq_l; v.res_l = res_l;
    v.rdy = rdy; v.sync = sync; v.i_flag = i_flag;
    v.e   = ph(s, src);
    v.tag = cur_tag;
    v.idx = tbl.size();
    tbl.push_back(v);
  endtask

  task automatic add_seq(input logic nmi_l, irq_l, input logic [1:0] src);
    for (int s = 1; s <= 7; s++) add(nmi_l, irq_l, 1, 1, 0, 0, s, src);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.NMI_L  = tbl[i].nmi_l;
      bus.IRQ_L  = tbl[i].irq_l;
      bus.RES_L  = tbl[i].res_l;
      bus.RDY    = tbl[i].rdy;
      bus.SYNC   = tbl[i].sync;
      bus.I_flag = tbl[i].i_flag;
      sb.push_back(tbl[i]);
      @(posedge clock);
      #1;
    end
    tbl.delete();
    cur_tag++;
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      vec_t v;
      v = sb.pop_front();
      check($sformatf("t%0d_c%0d", v.tag, v.idx), sample(), v.e);
    end
  end

  initial begin
    reset      = 1'b1;
    bus.NMI_L  = 1'b1;
    bus.IRQ_L  = 1'b1;
    bus.RES_L  = 1'b1;
    bus.RDY    = 1'b1;
    bus.SYNC   = 1'b0;
    bus.I_flag = 1'b0;
    @(posedge clock); #1;
    check("reset_c0", sample(), ph(IDLE, 0));
    @(posedge clock); #1;
    check("reset_c1", sample(), ph(IDLE, 0));
    reset = 1'b0;

    // t0: RES_L low three cycles, then reset entry with reads only.
    add(1, 1, 0, 1, 0, 0, IDLE, 0);
    add(1, 1, 0, 1, 0, 0, RHOLD, 0);
    add(1, 1, 0, 1, 0, 0, RHOLD, 0);
    add(1, 1, 1, 1, 0, 0, RHOLD, 0);
    add_seq(1, 1, 1);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    run_tbl();

    // t1: IRQ entry, then masked IRQ and a stalled boundary are both ignored.
    add(1, 0, 1, 1, 1, 0, IDLE, 0);
    add_seq(1, 0, 3);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    add(1, 0, 1, 1, 1, 1, IDLE, 0);
    add(1, 0, 1, 1, 0, 1, IDLE, 0);
    add(1, 0, 1, 0, 1, 0, IDLE, 0);
    add(1, 1, 1, 1, 1, 0, IDLE, 0);
    run_tbl();

    // t2: NMI edge and IRQ at the same boundary; NMI first, IRQ at next boundary.
    add(0, 0, 1, 1, 1, 0, IDLE, 0);
    add_seq(0, 0, 2);
    add(0, 0, 1, 1, 0, 0, IDLE, 0);
    add(0, 0, 1, 1, 1, 0, IDLE, 0);
    add_seq(0, 0, 3);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    run_tbl();

    // t3: NMI edge during S3 of an IRQ entry.
    add(1, 0, 1, 1, 1, 0, IDLE, 0);
    add(1, 0, 1, 1, 0, 0, 1, 3);
    add(1, 0, 1, 1, 0, 0, 2, 3);
    add(0, 0, 1, 1, 0, 0, 3, 3);
    add(0, 0, 1, 1, 0, 0, 4, 3);
    add(0, 0, 1, 1, 0, 0, 5, 3);
`ifdef INT_NMI_HIJACK_EN
    add(0, 0, 1, 1, 0, 0, 6, 2);
    add(0, 1, 1, 1, 0, 0, 7, 2);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    add(1, 1, 1, 1, 1, 0, IDLE, 0);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
`else
    add(0, 0, 1, 1, 0, 0, 6, 3);
    add(0, 1, 1, 1, 0, 0, 7, 3);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    add(1, 1, 1, 1, 1, 0, IDLE, 0);
    add_seq(1, 1, 2);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
`endif
    run_tbl();

    // t4: RDY low two cycles in S2 (stretches) and in S4/S5 (ignored): 9 busy cycles.
    add(1, 0, 1, 1, 1, 0, IDLE, 0);
    add(1, 0, 1, 1, 0, 0, 1, 3);
    add(1, 0, 1, 0, 0, 0, 2, 3);
    add(1, 0, 1, 0, 0, 0, 2, 3);
    add(1, 0, 1, 1, 0, 0, 2, 3);
    add(1, 0, 1, 1, 0, 0, 3, 3);
    add(1, 0, 1, 0, 0, 0, 4, 3);
    add(1, 0, 1, 0, 0, 0, 5, 3);
    add(1, 0, 1, 1, 0, 0, 6, 3);
    add(1, 1, 1, 1, 0, 0, 7, 3);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    run_tbl();

    // t5: RES_L falls in S4 of an IRQ entry with an NMI pending; RES aborts and drops the NMI.
    add(1, 0, 1, 1, 1, 0, IDLE, 0);
    add(1, 0, 1, 1, 0, 0, 1, 3);
    add(0, 0, 1, 1, 0, 0, 2, 3);
    add(0, 0, 1, 1, 0, 0, 3, 3);
    add(0, 1, 0, 1, 0, 0, 4, 3);
    add(0, 1, 1, 1, 0, 0, RHOLD, 0);
    add_seq(0, 1, 1);
    add(0, 1, 1, 1, 1, 0, IDLE, 0);
    add(1, 1, 1, 1, 0, 0, IDLE, 0);
    run_tbl();

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
